signals_vddh_seq: RTL

- Digital timing sequencer in the VDDH core domain. It turns one-cycle read/write requests into the ordered, non-overlapping array control pulses WRITE_VDDH, READ_VDDH, PRE_H, DVLP_H, SA_EN_H and dummy_en.
- Its outputs feed signals_vddl directly, which level-shifts them into the VDDL array domain.
- All outputs are registered, so the downstream shifter sees glitch-free levels.

---
 rtl/signals_vddh_pkg.sv | 27 ++
 rtl/signals_vddh_phase_cnt.sv | 26 ++
 rtl/signals_vddh_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/signals_vddh_pkg.sv
// Shared types and default phase lengths for the VDDH array timing sequencer.
package signals_vddh_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_GAP1  = 3'd2,
    ST_DVLP  = 3'd3,
    ST_GAP2  = 3'd4,
    ST_SENSE = 3'd5,
    ST_WRITE = 3'd6,
    ST_FIN   = 3'd7
  } state_e;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_PRE_CYCLES  = 4;
  localparam int DEF_DVLP_CYCLES = 6;
  localparam int DEF_SA_CYCLES   = 3;
  localparam int DEF_WR_CYCLES   = 10;
  localparam int DEF_GAP_CYCLES  = 1;

  function automatic logic is_read_phase(state_e s);
    return (s == ST_PRE) || (s == ST_GAP1) || (s == ST_DVLP) ||
           (s == ST_GAP2) || (s == ST_SENSE);
  endfunction

endpackage

// File: rtl/signals_vddh_phase_cnt.sv
// Loadable saturating down-counter timing one sequencer phase; zero marks the last cycle.
module signals_vddh_phase_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/signals_vddh_seq.sv
// VDDH array timing sequencer: read/write requests to ordered, non-overlapping control pulses.
// Macro SIGNALS_VDDH_DUMMY_GATE_EN gates dummy_en to read phases; otherwise it is 1 out of reset.
//
// state    | meaning
// ST_IDLE  | waiting for START
// ST_PRE   | bitline precharge
// ST_GAP1  | guard between precharge and develop
// ST_DVLP  | bitline develop
// ST_GAP2  | guard between develop and sense
// ST_SENSE | sense-amp enabled
// ST_WRITE | write driver enabled
// ST_FIN   | one-cycle DONE
module signals_vddh_seq
  import signals_vddh_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PRE_CYCLES  = DEF_PRE_CYCLES,
  parameter int DVLP_CYCLES = DEF_DVLP_CYCLES,
  parameter int SA_CYCLES   = DEF_SA_CYCLES,
  parameter int WR_CYCLES   = DEF_WR_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic START,
  input  logic RW,
  input  logic ABORT,
  output logic BUSY,
  output logic DONE,
  output logic WRITE_VDDH,
  output logic READ_VDDH,
  output logic PRE_H,
  output logic DVLP_H,
  output logic SA_EN_H,
  output logic dummy_en
);

  localparam int MAX_LEN = (1 << CNT_W) - 1;

  if ((PRE_CYCLES < 1) || (PRE_CYCLES > MAX_LEN)) begin : g_bad_pre
    $error("signals_vddh_seq: PRE_CYCLES out of range");
  end
  if ((DVLP_CYCLES < 1) || (DVLP_CYCLES > MAX_LEN)) begin : g_bad_dvlp
    $error("signals_vddh_seq: DVLP_CYCLES out of range");
  end
  if ((SA_CYCLES < 1) || (SA_CYCLES > MAX_LEN)) begin : g_bad_sa
    $error("signals_vddh_seq: SA_CYCLES out of range");
  end
  if ((WR_CYCLES < 1) || (WR_CYCLES > MAX_LEN)) begin : g_bad_wr
    $error("signals_vddh_seq: WR_CYCLES out of range");
  end
  if ((GAP_CYCLES < 0) || (GAP_CYCLES > MAX_LEN)) begin : g_bad_gap
    $error("signals_vddh_seq: GAP_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DVLP_LOAD = CNT_W'(DVLP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SA_LOAD   = CNT_W'(SA_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

  state_e           state_q, state_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  signals_vddh_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (START && !ABORT) begin
          cnt_load = 1'b1;
          if (RW) begin
            state_d = ST_WRITE;
            cnt_val = WR_LOAD;
          end else begin
            state_d = ST_PRE;
            cnt_val = PRE_LOAD;
          end
        end
      end
      ST_PRE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          state_d  = HAS_GAP ? ST_GAP1 : ST_DVLP;
          cnt_val  = HAS_GAP ? GAP_LOAD : DVLP_LOAD;
        end
      end
      ST_GAP1: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          state_d  = ST_DVLP;
          cnt_val  = DVLP_LOAD;
        end
      end
      ST_DVLP: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          state_d  = HAS_GAP ? ST_GAP2 : ST_SENSE;
          cnt_val  = HAS_GAP ? GAP_LOAD : SA_LOAD;
        end
      end
      ST_GAP2: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          state_d  = ST_SENSE;
          cnt_val  = SA_LOAD;
        end
      end
      ST_SENSE: if (cnt_zero) state_d = ST_FIN;
      ST_WRITE: if (cnt_zero) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Abort wins over any phase completion decided above.
    if (ABORT && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      cnt_load = 1'b0;
    end
  end

  // Outputs register the decode of the next state so they line up with state_q, glitch-free.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      WRITE_VDDH <= 1'b0;
      READ_VDDH  <= 1'b0;
      PRE_H      <= 1'b0;
      DVLP_H     <= 1'b0;
      SA_EN_H    <= 1'b0;
      dummy_en   <= 1'b0;
    end else begin
      BUSY       <= (state_d != ST_IDLE) && (state_d != ST_FIN);
      DONE       <= (state_d == ST_FIN);
      WRITE_VDDH <= (state_d == ST_WRITE);
      READ_VDDH  <= is_read_phase(state_d);
      PRE_H      <= (state_d == ST_PRE);
      DVLP_H     <= (state_d == ST_DVLP);
      SA_EN_H    <= (state_d == ST_SENSE);
`ifdef SIGNALS_VDDH_DUMMY_GATE_EN
      dummy_en   <= is_read_phase(state_d);
`else
      dummy_en   <= 1'b1;
`endif
    end
  end

endmodule
